// File: rtl/inst_fetch_unit_if.sv
// Fetch unit bus bundle: cache instruction request/response port plus the
// decoder-facing instruction queue head port. master = fetch unit side.
interface inst_fetch_unit_if;
    logic        need_inst;
    logic [31:0] inst_addr;
    logic        inst_handle;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic        iq_valid;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
    logic        iq_pred_taken;
    logic        iq_pop;

    modport master (
        output need_inst, inst_addr, iq_valid, iq_inst, iq_pc, iq_pred_taken,
        input  inst_handle, inst_ready, inst_out, iq_pop
    );

    modport slave (
        input  need_inst, inst_addr, iq_valid, iq_inst, iq_pc, iq_pred_taken,
        output inst_handle, inst_ready, inst_out, iq_pop
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: fetch PC, one outstanding cache request, circular instruction queue.
// Optional JAL target prediction when FETCH_JAL_PREDICT_EN is defined.
module inst_fetch_unit #(
    parameter int unsigned IQ_DEPTH = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              rob_clear,
    input  logic [31:0]       clear_pc,
    inst_fetch_unit_if.master bus
);
    localparam int unsigned    PTR_W    = $clog2(IQ_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(IQ_DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]       state;
    logic [31:0]      pc;
    logic [31:0]      next_pc;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic [31:0] inst_mem [IQ_DEPTH];
    logic [31:0] pc_mem   [IQ_DEPTH];

    logic flush;
    logic req;
    logic hit;
    logic miss;
    logic fill;
    logic push;
    logic pop;

    // A flush wins over any same-cycle cache response or decoder pop.
    always_comb begin
        flush = rdy_in && rob_clear;
        req   = rdy_in && (state == S_IDLE) && (count != FULL_CNT) && !rob_clear;
        hit   = req && bus.inst_handle && bus.inst_ready;
        miss  = req && bus.inst_handle && !bus.inst_ready;
        fill  = rdy_in && !rob_clear && (state == S_WAIT) && bus.inst_ready;
        push  = hit || fill;
        pop   = rdy_in && !rob_clear && bus.iq_pop && (count != '0);
    end

`ifdef FETCH_JAL_PREDICT_EN
    logic        is_jal;
    logic [31:0] j_imm;
    logic        pred_mem [IQ_DEPTH];

    always_comb begin
        is_jal  = (bus.inst_out[6:0] == 7'b1101111);
        j_imm   = {{12{bus.inst_out[31]}}, bus.inst_out[19:12], bus.inst_out[20],
                   bus.inst_out[30:21], 1'b0};
        next_pc = is_jal ? (pc + j_imm) : (pc + 32'd4);
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            pred_mem[tail] <= is_jal;
        end
    end

    // Gated so the flag reads 0 out of reset even though storage is not reset.
    always_comb begin
        bus.iq_pred_taken = (count != '0) && pred_mem[head];
    end
`else
    always_comb begin
        next_pc           = pc + 32'd4;
        bus.iq_pred_taken = 1'b0;
    end
`endif

    always_comb begin
        bus.need_inst = req;
        bus.inst_addr = pc;
        bus.iq_valid  = (count != '0);
        bus.iq_inst   = inst_mem[head];
        bus.iq_pc     = pc_mem[head];
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            pc    <= clear_pc;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (miss) begin
                state <= S_WAIT;
            end else if (fill) begin
                state <= S_IDLE;
            end

            if (push) begin
                pc   <= next_pc;
                tail <= tail + PTR_W'(1);
            end

            if (pop) begin
                head <= head + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            inst_mem[tail] <= bus.inst_out;
            pc_mem[tail]   <= pc;
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based reference model.
module tb_inst_fetch_unit;
    localparam int unsigned DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        rob_clear;
    logic [31:0] clear_pc;

    inst_fetch_unit_if bus ();

    inst_fetch_unit #(
        .IQ_DEPTH(DEPTH),
        .RESET_PC(32'h0)
    ) dut (
        .clk_in   (clk),
        .rst_in   (rst_n),
        .rdy_in   (rdy),
        .rob_clear(rob_clear),
        .clear_pc (clear_pc),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpc;
    bit          mwait;
    bit          mvalid;

    int pass_cnt;
    int total_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                               output logic pred);
        int signed imm;
        pred = 1'b0;
`ifdef FETCH_JAL_PREDICT_EN
        if (w[6:0] == 7'h6F) begin
            imm = int'(w[31]) * -1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                  + int'(w[30:21]) * 2;
            pred = 1'b1;
            return p + 32'(imm);
        end
`endif
        imm = 4;
        return p + 32'(imm);
    endfunction

    task automatic compare_model();
        bit exp_need;
        if (!mvalid) return;
        exp_need = rdy && !mwait && (mq.size() < DEPTH) && !rob_clear;
        check("need_inst", 32'(bus.need_inst), 32'(exp_need));
        check("inst_addr", bus.inst_addr, mpc);
        check("iq_valid", 32'(bus.iq_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("iq_inst", bus.iq_inst, mq[0].inst);
            check("iq_pc", bus.iq_pc, mq[0].pc);
            check("iq_pred_taken", 32'(bus.iq_pred_taken), 32'(mq[0].pred));
        end
    endtask

    task automatic model_step();
        bit   req;
        bit   got;
        ent_t e;
        logic pr;
        if (!rst_n) begin
            mpc = 32'h0; mwait = 0; mq.delete(); mvalid = 1;
            return;
        end
        if (!mvalid || !rdy) return;
        if (rob_clear) begin
            mpc = clear_pc; mwait = 0; mq.delete();
            return;
        end
        req = !mwait && (mq.size() < DEPTH);
        got = 0;
        if (req && bus.inst_handle && bus.inst_ready) got = 1;
        else if (req && bus.inst_handle) mwait = 1;
        else if (mwait && bus.inst_ready) begin got = 1; mwait = 0; end
        if (bus.iq_pop && mq.size() != 0) void'(mq.pop_front());
        if (got) begin
            e.inst = bus.inst_out;
            e.pc   = mpc;
            mpc    = model_next(mpc, bus.inst_out, pr);
            e.pred = pr;
            mq.push_back(e);
        end
    endtask

    task automatic step_begin();
        @(negedge clk);
        compare_model();
    endtask

    task automatic step_end();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit rd, input bit cl, input logic [31:0] cp,
                         input bit h, input bit rr, input logic [31:0] w, input bit p);
        rst_n = r; rdy = rd; rob_clear = cl; clear_pc = cp;
        bus.inst_handle = h; bus.inst_ready = rr; bus.inst_out = w; bus.iq_pop = p;
    endtask

    task automatic do_reset();
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        step_begin(); step_end();
        drive(1, 1, 0, 0, 0, 0, 0, 0);
    endtask

    logic [31:0] exp_jal_addr;
    logic        exp_jal_pred;

    initial begin
        pass_cnt = 0; total_cnt = 0; mvalid = 0; mwait = 0; mpc = 0;
`ifdef FETCH_JAL_PREDICT_EN
        exp_jal_addr = 32'h30; exp_jal_pred = 1'b1;
`else
        exp_jal_addr = 32'h24; exp_jal_pred = 1'b0;
`endif
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        #1;
        do_reset();

        // Reset state, then three back-to-back hits
        step_begin();
        check("rst_need", 32'(bus.need_inst), 1);
        check("rst_addr", bus.inst_addr, 32'h0);
        check("rst_valid", 32'(bus.iq_valid), 0);
        check("rst_pred", 32'(bus.iq_pred_taken), 0);
        step_end();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 1, 1, 32'h13, 0);
            step_begin(); step_end();
        end
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        step_begin();
        check("hit_addr", bus.inst_addr, 32'hC);
        check("model_qsize", 32'(mq.size()), 3);
        step_end();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 1);
            step_begin();
            check("hit_pc", bus.iq_pc, 32'(i * 4));
            step_end();
        end

        // Miss: accepted at t, data at t+5
        do_reset();
        drive(1, 1, 0, 0, 1, 0, 0, 0);
        step_begin(); check("miss_req", 32'(bus.need_inst), 1); step_end();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 0, 1, (i == 4), 32'h00A00093, 0);
            step_begin(); check("miss_wait_need", 32'(bus.need_inst), 0); step_end();
        end
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        step_begin();
        check("miss_need", 32'(bus.need_inst), 1);
        check("miss_addr", bus.inst_addr, 32'h4);
        check("miss_inst", bus.iq_inst, 32'h00A00093);
        check("miss_pc", bus.iq_pc, 32'h0);
        step_end();

        // Fill the queue, then a single pop reopens requests
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 0, 0, 1, 1, 32'h13, 0);
            step_begin(); step_end();
        end
        drive(1, 1, 0, 0, 0, 0, 0, 1);
        step_begin();
        check("full_need", 32'(bus.need_inst), 0);
        check("full_addr", bus.inst_addr, 32'h20);
        step_end();

        // JAL hit at 0x20
        drive(1, 1, 0, 0, 1, 1, 32'h0100006F, 0);
        step_begin();
        check("jal_need", 32'(bus.need_inst), 1);
        check("jal_req_addr", bus.inst_addr, 32'h20);
        step_end();
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        step_begin(); check("jal_next_addr", bus.inst_addr, exp_jal_addr); step_end();
        for (int i = 0; i < 7; i++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 1);
            step_begin(); step_end();
        end
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        step_begin();
        check("jal_pc", bus.iq_pc, 32'h20);
        check("jal_pred", 32'(bus.iq_pred_taken), 32'(exp_jal_pred));
        step_end();

        // Miss, then flush with a same-cycle response
        drive(1, 1, 0, 0, 1, 0, 0, 1);
        step_begin(); step_end();
        drive(1, 1, 1, 32'h100, 0, 1, 32'h13, 0);
        step_begin(); check("flush_need", 32'(bus.need_inst), 0); step_end();
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        step_begin();
        check("flush_valid", 32'(bus.iq_valid), 0);
        check("flush_need_after", 32'(bus.need_inst), 1);
        check("flush_addr", bus.inst_addr, 32'h100);
        step_end();

        // PC wrap at the top of the address space, then rdy_in freeze
        drive(1, 1, 1, 32'hFFFFFFFC, 0, 0, 0, 0);
        step_begin(); step_end();
        drive(1, 1, 0, 0, 1, 1, 32'h13, 0);
        step_begin(); step_end();
        drive(1, 0, 0, 0, 1, 1, 32'h13, 1);
        step_begin(); check("frz_need", 32'(bus.need_inst), 0); step_end();
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        step_begin();
        check("wrap_addr", bus.inst_addr, 32'h0);
        check("frz_pc", bus.iq_pc, 32'hFFFFFFFC);
        step_end();

        // Randomized traffic with varying pop pressure
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] w;
            int unsigned pop_pct;
            pop_pct = ((n / 400) % 2 == 0) ? 20 : 70;
            w = $urandom;
            if ($urandom_range(0, 3) == 0) w[6:0] = 7'h6F;
            drive($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 29) == 0, $urandom & 32'hFFFFFFFC,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, w,
                  $urandom_range(0, 99) < pop_pct);
            step_begin(); step_end();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
